// File: rtl/lutram_readback.sv
// rtl/lutram_readback.sv - sequential read-out engine streaming a 64x8 LUT RAM bank over valid/ready
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           one-cycle burst request, sampled only when idle
//   base_addr       first word address of the burst, sampled with start
//   len             burst length in words; 0 = empty burst, values above depth clamp to depth
//   abort           terminates an active burst without a done pulse
//   rd_addr         registered read address shared by all RAM slices
//   rd_data         asynchronous read data, bit i from slice i
//   m_valid/m_ready output word handshake
//   m_data, m_last  output word and final-word marker
//   busy            burst in progress
//   done            one-cycle pulse on normal burst completion
module lutram_readback #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state;
    logic [ADDR_W:0] remaining;
    logic [ADDR_W:0] len_clamped;
    logic            load;
    logic            accept;

    assign len_clamped = (len > DEPTH) ? DEPTH : len;

    // remaining is zero outside READ, so load can only fire while reading.
    // The output register refills whenever it is empty or being drained.
    assign load   = (remaining != '0) && (!m_valid || m_ready);
    assign accept = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            rd_addr   <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_clamped != '0) begin
                            state     <= READ;
                            busy      <= 1'b1;
                            rd_addr   <= base_addr;
                            remaining <= len_clamped;
                        end else begin
                            // Empty burst completes immediately with no beats.
                            done <= 1'b1;
                        end
                    end
                end

                READ: begin
                    if (abort) begin
                        state     <= IDLE;
                        m_valid   <= 1'b0;
                        m_last    <= 1'b0;
                        busy      <= 1'b0;
                        remaining <= '0;
                    end else if (load) begin
                        // rd_data reflects the RAM before any write on this
                        // same edge, so a colliding write is not observed.
                        m_data    <= rd_data;
                        m_valid   <= 1'b1;
                        m_last    <= (remaining == ONE);
                        rd_addr   <= rd_addr + 1'b1;
                        remaining <= remaining - ONE;
                        if (remaining == ONE) begin
                            state <= FLUSH;
                        end
                    end
                end

                FLUSH: begin
                    if (abort) begin
                        state     <= IDLE;
                        m_valid   <= 1'b0;
                        m_last    <= 1'b0;
                        busy      <= 1'b0;
                        remaining <= '0;
                    end else if (accept) begin
                        state   <= IDLE;
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lutram_readback.sv
// tb/tb_lutram_readback.sv - randomized self-checking bench for lutram_readback
module tb_lutram_readback;

    localparam int AW = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          abort = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;

    logic [7:0]    mem [64];
    logic          load_pat = 1'b0;
    logic          we = 1'b0;
    logic [5:0]    waddr = '0;
    logic [7:0]    wdata = '0;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // RAM bank model: synchronous write, asynchronous read.
    assign rd_data = mem[rd_addr];

    always @(posedge clk) begin
        if (load_pat) begin
            for (int k = 0; k < 64; k++) mem[k] <= 8'(k) ^ 8'hA5;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    lutram_readback #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .abort     (abort),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One burst checked against a word-list model: the expected stream is
    // simply the RAM contents at base, base+1, ... (mod 64), min(len,64) words.
    task automatic run_burst(input int base, input int ln, input int mode,
                             input int abort_at, input bit poke, input bit collide);
        int         n;
        int         acc;
        int         loaded;
        bit         prev_stall;
        bit         wrote;
        logic [7:0] held;
        logic [7:0] e;
        logic [7:0] exp_q[$];

        n = (ln > 64) ? 64 : ln;
        for (int k = 0; k < n; k++) exp_q.push_back(mem[(base + k) % 64]);

        start     = 1'b1;
        base_addr = AW'(base);
        len       = (AW+1)'(ln);
        m_ready   = 1'b0;
        @(negedge clk);
        start = 1'b0;

        if (n == 0) begin
            check_eq("empty_done", done, 1);
            check_eq("empty_busy", busy, 0);
            check_eq("empty_valid", m_valid, 0);
            @(negedge clk);
            check_eq("empty_done_pulse", done, 0);
            check_eq("empty_valid2", m_valid, 0);
            return;
        end

        check_eq("start_busy", busy, 1);
        check_eq("start_addr", rd_addr, base % 64);
        check_eq("start_valid", m_valid, 0);

        acc        = 0;
        prev_stall = 1'b0;
        wrote      = 1'b0;
        held       = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 6 == 0) || (cyc % 6 == 3) || (cyc % 6 == 5);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase

            loaded = acc + (m_valid ? 1 : 0);
            check_eq("rd_addr_seq", rd_addr, (base + loaded) % 64);
            if (m_valid && prev_stall) check_eq("stall_hold", m_data, held);

            if (poke && cyc == 2) begin
                start     = 1'b1;
                base_addr = AW'($urandom);
                len       = 7'd5;
            end

            if (collide && !wrote && rd_addr == 6'd5 && (!m_valid || m_ready) && loaded < n) begin
                we    = 1'b1;
                waddr = 6'd5;
                wdata = 8'hFF;
                wrote = 1'b1;
            end

            if (abort_at >= 0 && acc == abort_at && m_valid) begin
                abort   = 1'b1;
                m_ready = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check_eq("abort_valid", m_valid, 0);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_last", m_last, 0);
                check_eq("abort_done", done, 0);
                @(negedge clk);
                check_eq("abort_done2", done, 0);
                check_eq("abort_busy2", busy, 0);
                return;
            end

            if (m_valid) check_eq("beat_last", m_last, acc == n - 1);
            if (m_valid && m_ready) begin
                e = exp_q.pop_front();
                check_eq("beat_data", m_data, e);
                acc++;
            end

            prev_stall = m_valid && !m_ready;
            held       = m_data;
            @(negedge clk);
            start = 1'b0;
            we    = 1'b0;

            if (acc == n) begin
                check_eq("end_done", done, 1);
                check_eq("end_busy", busy, 0);
                check_eq("end_valid", m_valid, 0);
                check_eq("end_last", m_last, 0);
                @(negedge clk);
                check_eq("end_done_pulse", done, 0);
                check_eq("end_busy2", busy, 0);
                return;
            end
            check_eq("no_early_done", done, 0);
            check_eq("mid_busy", busy, 1);
        end
        check_eq("burst_timeout", acc, n);
    endtask

    initial begin
        rst_n    = 1'b0;
        load_pat = 1'b1;
        repeat (2) @(negedge clk);
        load_pat = 1'b0;
        check_eq("rst_rd_addr", rd_addr, 0);
        check_eq("rst_valid", m_valid, 0);
        check_eq("rst_data", m_data, 0);
        check_eq("rst_last", m_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full sweep, then data held while idle.
        run_burst(0, 64, 0, -1, 1'b0, 1'b0);
        check_eq("idle_data_hold", m_data, 8'd63 ^ 8'hA5);

        // Wrap-around burst.
        run_burst(62, 4, 0, -1, 1'b0, 1'b0);

        // Back-pressure pattern with an ignored mid-burst start.
        run_burst(int'($urandom_range(0, 63)), 8, 1, -1, 1'b1, 1'b0);

        // Empty and oversize bursts.
        run_burst(int'($urandom_range(0, 63)), 0, 0, -1, 1'b0, 1'b0);
        run_burst(int'($urandom_range(0, 63)), 100, 0, -1, 1'b0, 1'b0);

        // Abort after three accepted beats, then a fresh short burst.
        run_burst(20, 10, 0, 3, 1'b0, 1'b0);
        run_burst(40, 2, 0, -1, 1'b0, 1'b0);

        // Abort while idle does nothing.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("idle_abort_busy", busy, 0);
        check_eq("idle_abort_valid", m_valid, 0);
        check_eq("idle_abort_done", done, 0);

        // Write collides with the load of address 5; then read back the new value.
        run_burst(0, 8, 0, -1, 1'b0, 1'b1);
        run_burst(4, 3, 0, -1, 1'b0, 1'b0);

        // Randomized bursts with random back-pressure.
        for (int i = 0; i < 8; i++) begin
            run_burst(int'($urandom_range(0, 63)), int'($urandom_range(0, 100)), 2, -1, 1'b1, 1'b0);
        end

        // Reset asserted between clock edges mid-burst.
        start     = 1'b1;
        base_addr = 6'd10;
        len       = 7'd20;
        m_ready   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("pre_rst_valid", m_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("async_rst_addr", rd_addr, 0);
        check_eq("async_rst_valid", m_valid, 0);
        check_eq("async_rst_data", m_data, 0);
        check_eq("async_rst_last", m_last, 0);
        check_eq("async_rst_busy", busy, 0);
        check_eq("async_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_busy", busy, 0);
        check_eq("post_rst_done", done, 0);
        check_eq("post_rst_valid", m_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
